// File: rtl/cmt_rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// cmt_rx_fifo_ctrl
//
// Receive-side byte FIFO between the PC-8001 core's cassette (CMT) byte strobe
// and the Nios II sub-system bus. Software drains bytes through an Avalon-MM
// slave port. Reading DATA pops one entry. A sticky overflow flag records
// bytes dropped while the FIFO was full. An optional level interrupt is raised
// while data is pending or overflow is set.
//
// Build option:
//   CMT_RX_FIFO_IRQ_EN  defined   -> irq_en register and irq output are built
//                       undefined -> irq tied to 0, CONTROL bit2 reads 0
//
// Parameters:
//   DEPTH_LOG2   FIFO depth is 2**DEPTH_LOG2 entries (2..6)
//
// Ports:
//   clk          system clock, all state on its rising edge
//   reset        synchronous active-high reset
//   in_data      CMT byte from the core
//   in_valid     in_data valid this cycle
//   in_ready     FIFO not full (from registered count only)
//   address      Avalon word address (0 DATA, 1 STATUS, 2 CONTROL, 3 unused)
//   chipselect   Avalon slave select
//   read         Avalon read strobe
//   write        Avalon write strobe
//   writedata    Avalon write data
//   readdata     registered read data, 1-cycle latency, held until next read
//   irq          registered level interrupt request
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module cmt_rx_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_COUNT  = (DEPTH_LOG2 + 1)'(1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  overflow_reg;
  logic [31:0]           readdata_reg;

  logic [DEPTH_LOG2-1:0] wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_next;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  overflow_next;
  logic [31:0]           readdata_next;

  // Current value of the interrupt enable, constant 0 when not built.
  logic                  irq_en;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic rd_sel;
  logic wr_sel;
  logic empty;
  logic full;
  logic ctrl_wr;
  logic flush;
  logic clr_ovf;
  logic pop;
  logic push;
  logic ovf_set;

  always_comb begin
    rd_sel  = chipselect && read;
    wr_sel  = chipselect && write;
    empty   = (count_reg == '0);
    full    = (count_reg == FULL_COUNT);
    ctrl_wr = wr_sel && (address == ADDR_CONTROL);
    flush   = ctrl_wr && writedata[0];
    clr_ovf = ctrl_wr && writedata[1];
    pop     = rd_sel && (address == ADDR_DATA) && !empty;
    // Flush takes precedence over an incoming byte: it is silently dropped and
    // does not count as an overflow.
    push    = in_valid && !full && !flush;
    ovf_set = in_valid && full && !flush;
  end

  // in_ready is a pure function of the registered count; it never anticipates
  // a same-cycle pop.
  assign in_ready = !full;

  // ---------------------------------------------------------------------------
  // Next-state for pointers, count and overflow
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_next = count_reg + ONE_COUNT;
        2'b01:   count_next = count_reg - ONE_COUNT;
        default: count_next = count_reg;
      endcase
    end

    // Setting beats clearing when both happen in one cycle.
    if (ovf_set) begin
      overflow_next = 1'b1;
    end else if (clr_ovf) begin
      overflow_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data mux
  // ---------------------------------------------------------------------------
  logic [31:0] status_word;
  logic [31:0] control_word;

  always_comb begin
    status_word                 = '0;
    status_word[DEPTH_LOG2:0]   = count_reg;
    status_word[8]              = empty;
    status_word[9]              = full;
    status_word[10]             = overflow_reg;

    control_word    = '0;
    control_word[2] = irq_en;
  end

  always_comb begin
    // Without a read strobe the previous read value is held.
    readdata_next = readdata_reg;
    if (rd_sel) begin
      unique case (address)
        ADDR_DATA: begin
          if (empty) begin
            readdata_next = '0;
          end else begin
            readdata_next = {23'b0, 1'b1, mem[rd_ptr_reg]};
          end
        end
        ADDR_STATUS:  readdata_next = status_word;
        ADDR_CONTROL: readdata_next = control_word;
        default:      readdata_next = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      readdata_reg <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      readdata_reg <= readdata_next;
    end
  end

  // Storage array carries no reset; stale contents are never observable
  // because count gates every read.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  assign readdata = readdata_reg;

  // ---------------------------------------------------------------------------
  // Interrupt
  // ---------------------------------------------------------------------------
`ifdef CMT_RX_FIFO_IRQ_EN
  logic irq_en_reg;
  logic irq_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en_reg <= writedata[2];
      end
      // Reflects the state as it stood before this edge, so irq trails the
      // FIFO by one cycle.
      irq_reg <= irq_en_reg && (!empty || overflow_reg);
    end
  end

  assign irq_en = irq_en_reg;
  assign irq    = irq_reg;

  logic unused_writedata;
  assign unused_writedata = ^writedata[31:3];
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;

  logic unused_writedata;
  assign unused_writedata = ^writedata[31:2];
`endif

endmodule

// File: tb/tb_cmt_rx_fifo_ctrl.sv
`timescale 1ns/1ps

module tb_cmt_rx_fifo_ctrl;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

`ifdef CMT_RX_FIFO_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  cmt_rx_fifo_ctrl #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  // Behavioural model: a byte queue plus flags.
  logic [7:0]  q[$];
  bit          m_ovf;
  bit          m_en;
  bit          m_irq;
  logic [31:0] m_rd;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int sz;
    bit full_pre, pop, flush, clr, set, irq_nx;
    if (reset) begin
      q.delete();
      m_ovf = 0; m_en = 0; m_irq = 0; m_rd = '0;
      return;
    end
    sz       = q.size();
    full_pre = (sz == DEPTH);
    irq_nx   = m_en && ((sz != 0) || m_ovf);
    pop = 0; set = 0;
    if (chipselect && read) begin
      case (address)
        2'd0: begin
          if (sz > 0) begin
            m_rd = 32'h100 | 32'(q[0]);
            pop  = 1;
          end else begin
            m_rd = '0;
          end
        end
        2'd1: m_rd = 32'(sz) | ((sz == 0) ? 32'h100 : 32'h0)
                     | (full_pre ? 32'h200 : 32'h0) | (m_ovf ? 32'h400 : 32'h0);
        2'd2: m_rd = m_en ? 32'h4 : 32'h0;
        default: m_rd = '0;
      endcase
    end
    flush = chipselect && write && (address == 2'd2) && writedata[0];
    clr   = chipselect && write && (address == 2'd2) && writedata[1];
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (in_valid) begin
        if (!full_pre) q.push_back(in_data);
        else set = 1;
      end
    end
    if (set) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (IRQ_BUILD && chipselect && write && (address == 2'd2)) m_en = writedata[2];
    m_irq = irq_nx;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("readdata", readdata, m_rd);
      check("in_ready", {31'b0, in_ready}, {31'b0, q.size() != DEPTH});
      check("irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    in_valid   = 0;
    chipselect = 0;
    read       = 0;
    write      = 0;
    address    = 0;
    writedata  = 0;
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1; in_data = b;
    tick();
    in_valid = 0;
    $display("push 0x%02h in_ready=%0b", b, in_ready);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1; read = 1; address = a;
    tick();
    chipselect = 0; read = 0;
    d = readdata;
    $display("read addr=%0d data=0x%08h", a, d);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    chipselect = 1; write = 1; address = a; writedata = v;
    tick();
    chipselect = 0; write = 0; writedata = 0;
    $display("write addr=%0d data=0x%08h", a, v);
  endtask

  logic [31:0] d;

  initial begin
    idle();
    in_data = 0;
    reset   = 1;
    repeat (3) tick();
    chk_on = 1;
    reset  = 0;

    // Reset state
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_irq", {31'b0, irq}, 32'd0);
    rd(2'd1, d); check("reset_status", d, 32'h100);

    // Push then drain
    push(8'h3A); push(8'hC5);
    rd(2'd1, d); check("status_two", d, 32'h2);
    rd(2'd0, d); check("data_3a", d, 32'h13A);
    rd(2'd0, d); check("data_c5", d, 32'h1C5);
    rd(2'd0, d); check("data_empty", d, 32'h0);
    rd(2'd1, d); check("status_empty", d, 32'h100);

    // Fill and overflow
    for (int i = 0; i < DEPTH; i++) begin
      push(8'(i));
      if (i == DEPTH - 2) check("in_ready_15", {31'b0, in_ready}, 32'd1);
    end
    check("in_ready_full", {31'b0, in_ready}, 32'd0);
    push(8'h99);
    rd(2'd1, d); check("status_ovf", d, 32'h610);
    for (int i = 0; i < DEPTH; i++) begin
      rd(2'd0, d); check("drain", d, 32'h100 | 32'(i));
    end
    wr(2'd2, 32'h2);
    rd(2'd1, d); check("ovf_cleared", d, 32'h100);

    // Simultaneous push/pop at count 5, then at full
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    chipselect = 1; read = 1; address = 0; in_valid = 1; in_data = 8'h65;
    tick();
    idle();
    check("sim_pop_data", readdata, 32'h160);
    rd(2'd1, d); check("sim_count5", d, 32'h5);
    for (int i = 0; i < 11; i++) push(8'h70 + 8'(i));
    rd(2'd1, d); check("full_16", d, 32'h210);
    chipselect = 1; read = 1; address = 0; in_valid = 1; in_data = 8'hEE;
    tick();
    idle();
    rd(2'd1, d); check("full_push_pop", d, 32'h40F);
    wr(2'd2, 32'h2);
    push(8'h88);
    // Flush with a same-cycle push against a full FIFO
    chipselect = 1; write = 1; address = 2; writedata = 32'h1; in_valid = 1; in_data = 8'hAB;
    tick();
    idle();
    rd(2'd1, d); check("flush_push", d, 32'h100);

    // Wrap-around
    for (int i = 0; i < 10; i++) push(8'h20 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      rd(2'd0, d); check("wrap_a", d, 32'h120 + 32'(i));
    end
    for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      rd(2'd0, d); check("wrap_b", d, 32'h140 + 32'(i));
    end

    // Interrupt
    wr(2'd2, 32'h4);
    tick();
    check("irq_empty", {31'b0, irq}, 32'd0);
    rd(2'd2, d); check("ctrl_read", d, IRQ_BUILD ? 32'h4 : 32'h0);
    push(8'h77);
    check("irq_push_edge", {31'b0, irq}, 32'd0);
    tick();
    check("irq_rise", {31'b0, irq}, {31'b0, IRQ_BUILD});
    rd(2'd0, d); check("irq_data", d, 32'h177);
    check("irq_pop_edge", {31'b0, irq}, {31'b0, IRQ_BUILD});
    tick();
    check("irq_fall", {31'b0, irq}, 32'd0);

    // Randomized traffic checked by the per-cycle compare process
    for (int c = 0; c < 3000; c++) begin
      int op;
      logic [31:0] wd;
      reset    = ($urandom_range(0, 999) < 3);
      in_valid = $urandom_range(0, 1);
      in_data  = 8'($urandom);
      op       = $urandom_range(0, 9);
      chipselect = 0; read = 0; write = 0; writedata = 0;
      address  = $urandom_range(0, 1) ? 2'd0 : 2'($urandom_range(0, 3));
      if (op >= 4 && op <= 7) begin
        chipselect = 1; read = 1;
      end else if (op >= 8) begin
        wd = $urandom;
        if ($urandom_range(0, 15) != 0) wd[0] = 1'b0;
        chipselect = 1; write = 1; writedata = wd;
      end
      tick();
      $display("cycle %0d rst=%0b v=%0b cs=%0b r=%0b w=%0b a=%0d rdata=0x%08h lvl=%0d",
               c, reset, in_valid, chipselect, read, write, address, readdata, q.size());
    end
    reset = 0;
    idle();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
